// File: rtl/cache_data_pkg.sv
// Shared types and helpers for the cache data bank.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package cache_data_pkg;

  typedef enum logic {DA_INIT, DA_READY} da_state_t;

  // Byte-lane merge: take the new byte where the lane is enabled, keep the old one otherwise.
  // Applied per lane across a line wherever a masked line merge is needed.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       mask);
    return mask ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/cache_data_way.sv
// One cache way: SETS x LINE_BITS storage with a byte-masked write port.
// Latency: write lands at posedge; read is combinational with write-first forwarding.
// Backpressure: none; accepts a write every cycle.
module cache_data_way
  import cache_data_pkg::*;
#(
  parameter int S_INDEX    = 6,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [S_INDEX-1:0]      windex,
  input  logic [LINE_BYTES-1:0]   wmask,
  input  logic [8*LINE_BYTES-1:0] wdata,
  input  logic [S_INDEX-1:0]      rindex,
  output logic [8*LINE_BYTES-1:0] rline
);

  localparam int SETS = 2**S_INDEX;

  logic [8*LINE_BYTES-1:0] mem [SETS];

  // Storage update: enabled lanes take the write data, others keep their contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        mem[windex][8*b +: 8] <= byte_merge(mem[windex][8*b +: 8], wdata[8*b +: 8], wmask[b]);
      end
    end
  end

  // Read path: a same-cycle write to the same set is visible on the read (write-first).
  always_comb begin
    rline = mem[rindex];
    if (we && (rindex == windex)) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        rline[8*b +: 8] = byte_merge(rline[8*b +: 8], wdata[8*b +: 8], wmask[b]);
      end
    end
  end

endmodule

// File: rtl/cache_data_bank.sv
// Multi-way byte-maskable cache data bank with post-reset zeroing sweep.
// Latency: read data and rvalid registered, exactly 1 cycle after an accepted read.
// Backpressure: ready=0 during the sweep; ports are ignored until ready rises.
module cache_data_bank
  import cache_data_pkg::*;
#(
  parameter int S_INDEX    = 6,
  parameter int LINE_BYTES = 32,
  parameter int NUM_WAYS   = 2,
  parameter int W_WAY      = ($clog2(NUM_WAYS) > 0) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              ready,
  input  logic                              read_en,
  input  logic [S_INDEX-1:0]                rindex,
  output logic                              rvalid,
  output logic [NUM_WAYS*8*LINE_BYTES-1:0]  rdata,
  input  logic [LINE_BYTES-1:0]             wmask,
  input  logic [W_WAY-1:0]                  wway,
  input  logic [S_INDEX-1:0]                windex,
  input  logic [8*LINE_BYTES-1:0]           wdata
);

  localparam int LINE_BITS = 8*LINE_BYTES;

  da_state_t                     state, state_nxt;
  logic [S_INDEX-1:0]            sweep_cnt, sweep_cnt_nxt;
  logic                          sweeping;
  logic [S_INDEX-1:0]            wr_index;
  logic [LINE_BYTES-1:0]         wr_mask;
  logic [LINE_BITS-1:0]          wr_data;
  logic [NUM_WAYS*LINE_BITS-1:0] all_lines;

  assign ready    = (state == DA_READY);
  assign sweeping = (state == DA_INIT);

  // State and sweep counter registers; reset restarts the sweep at set 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DA_INIT;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  // Next state: sweep one set per cycle, go ready after the last set is written.
  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    case (state)
      DA_INIT: begin
        sweep_cnt_nxt = sweep_cnt + 1'b1;
        if (&sweep_cnt) state_nxt = DA_READY;
      end
      DA_READY: state_nxt = DA_READY;
      default:  state_nxt = DA_INIT;
    endcase
  end

  // Write-port mux: during the sweep every way gets a full-line zero write.
  always_comb begin
    wr_index = sweeping ? sweep_cnt : windex;
    wr_mask  = sweeping ? '1 : wmask;
    wr_data  = '0;
    for (int b = 0; b < LINE_BYTES; b++) begin
      wr_data[8*b +: 8] = byte_merge(wdata[8*b +: 8], 8'h00, sweeping);
    end
  end

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic                 way_we;
    logic [LINE_BITS-1:0] way_line;

    // Out-of-range wway values match no way and are therefore dropped.
    assign way_we = sweeping | ((|wmask) && (wway == W_WAY'(w)));

    cache_data_way #(
      .S_INDEX    (S_INDEX),
      .LINE_BYTES (LINE_BYTES)
    ) u_way (
      .clk    (clk),
      .we     (way_we),
      .windex (wr_index),
      .wmask  (wr_mask),
      .wdata  (wr_data),
      .rindex (rindex),
      .rline  (way_line)
    );

    assign all_lines[w*LINE_BITS +: LINE_BITS] = way_line;
  end

  // Read output registers; rdata holds its last value when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= ready && read_en;
      if (ready && read_en) rdata <= all_lines;
    end
  end

endmodule
